// File: rtl/dense_stream_layer.sv
// Streaming fully-connected layer: one bias beat, NUM_IN joint x/w beats with
// saturating MACs per lane, then an argmax result or a ReLU-quantised vector.
module dense_stream_layer #(
  parameter int unsigned NUM_OUT  = 10,
  parameter int unsigned NUM_IN   = 160,
  parameter int unsigned X_BITS   = 4,
  parameter int unsigned W_BITS   = 4,
  parameter int unsigned ACC_BITS = 16,
  parameter int unsigned B_SHIFT  = 4,
  parameter int unsigned A_SHIFT  = 4,
  localparam int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_OUT*W_BITS-1:0]   b_tdata,
  input  logic                        b_tvalid,
  output logic                        b_tready,
  input  logic [X_BITS-1:0]           x_tdata,
  input  logic                        x_tvalid,
  output logic                        x_tready,
  input  logic [NUM_OUT*W_BITS-1:0]   w_tdata,
  input  logic                        w_tvalid,
  output logic                        w_tready,
  input  logic                        mode,
  output logic [IDX_W-1:0]            a_tdata,
  output logic [ACC_BITS-1:0]         raw,
  output logic                        a_tvalid,
  input  logic                        a_tready,
  output logic [X_BITS-1:0]           y_tdata,
  output logic                        y_tlast,
  output logic                        y_tvalid,
  input  logic                        y_tready,
  output logic [1:0]                  status,
  output logic                        sat
);

  localparam int unsigned P_W   = W_BITS + X_BITS + 1;
  localparam int unsigned SUM_W = ACC_BITS + 1;
  localparam int unsigned CNT_W = $clog2(NUM_IN + 1);
  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic signed [ACC_BITS-1:0] Y_MAX = ACC_BITS'((1 << X_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REDUCE = 2'd2,
    S_OUT    = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic                             mode_q, mode_d;
  logic                             sat_q, sat_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]                 lane_q, lane_d;
  logic [NUM_OUT-1:0][ACC_BITS-1:0] acc_q, acc_d, acc_add;
  logic                             clamp_any;
  logic [IDX_W-1:0]                 a_idx_q, a_idx_d;
  logic [ACC_BITS-1:0]              raw_q, raw_d;
  logic                             a_valid_q, a_valid_d;
  logic [X_BITS-1:0]                y_data_q, y_data_d;
  logic                             y_last_q, y_last_d;
  logic                             y_valid_q, y_valid_d;
  logic                             b_rdy_q, b_rdy_d;
  logic [1:0]                       status_q, status_d;
  logic                             in_accum, b_fire, x_fire;

  // Arithmetic shift, then clamp to the unsigned activation range.
  function automatic logic [X_BITS-1:0] relu_q(input logic [ACC_BITS-1:0] a);
    logic signed [ACC_BITS-1:0] s;
    s = $signed(a) >>> A_SHIFT;
    if (s[ACC_BITS-1])  return '0;
    else if (s > Y_MAX) return '1;
    else                return s[X_BITS-1:0];
  endfunction

  assign in_accum = (state_q == S_ACCUM);
  assign b_fire   = b_rdy_q & b_tvalid;
  assign x_fire   = in_accum & x_tvalid & w_tvalid;
  assign b_tready = b_rdy_q;
  assign x_tready = in_accum & w_tvalid;
  assign w_tready = in_accum & x_tvalid;

  // Per-lane saturating multiply-accumulate of the current x/w beat.
  always_comb begin : mac
    logic signed [P_W-1:0]   prod;
    logic signed [SUM_W-1:0] sum;
    prod      = '0;
    sum       = '0;
    clamp_any = 1'b0;
    acc_add   = acc_q;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      prod = P_W'($signed(w_tdata[i*W_BITS +: W_BITS])) * P_W'($signed({1'b0, x_tdata}));
      sum  = SUM_W'($signed(acc_q[i])) + SUM_W'(prod);
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
        acc_add[i] = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        clamp_any  = 1'b1;
      end else begin
        acc_add[i] = sum[ACC_BITS-1:0];
      end
    end
  end

  always_comb begin : fsm
    state_d   = state_q;
    mode_d    = mode_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    a_idx_d   = a_idx_q;
    raw_d     = raw_q;
    a_valid_d = a_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_valid_d = y_valid_q;
    case (state_q)
      S_IDLE: begin
        if (b_fire) begin
          for (int i = 0; i < int'(NUM_OUT); i++) begin
            acc_d[i] = ACC_BITS'($signed(b_tdata[i*W_BITS +: W_BITS])) << B_SHIFT;
          end
          mode_d  = mode;
          sat_d   = 1'b0;
          cnt_d   = '0;
          lane_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (x_fire) begin
          acc_d = acc_add;
          sat_d = sat_q | clamp_any;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            lane_d = '0;
            if (mode_q) begin
              // ReLU mode skips the reduction; lane 0 comes from this beat's sums.
              state_d   = S_OUT;
              y_valid_d = 1'b1;
              y_data_d  = relu_q(acc_add[0]);
              y_last_d  = (NUM_OUT == 1);
            end else begin
              state_d = S_REDUCE;
            end
          end
        end
      end
      S_REDUCE: begin
        lane_d = lane_q + IDX_W'(1);
        if (lane_q == '0 || $signed(acc_q[lane_q]) > $signed(raw_q)) begin
          raw_d   = acc_q[lane_q];
          a_idx_d = lane_q;
        end
        if (lane_q == IDX_W'(NUM_OUT - 1)) begin
          a_valid_d = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (mode_q) begin
          if (y_tready) begin
            if (y_last_q) begin
              y_valid_d = 1'b0;
              y_last_d  = 1'b0;
              state_d   = S_IDLE;
            end else begin
              lane_d   = lane_q + IDX_W'(1);
              y_data_d = relu_q(acc_q[lane_q + IDX_W'(1)]);
              y_last_d = ((lane_q + IDX_W'(1)) == IDX_W'(NUM_OUT - 1));
            end
          end
        end else if (a_tready) begin
          a_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    b_rdy_d  = (state_d == S_IDLE);
    status_d = (state_d == S_IDLE) ? 2'b00 : (state_d == S_OUT) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
      lane_q    <= '0;
      acc_q     <= '0;
      a_idx_q   <= '0;
      raw_q     <= '0;
      a_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_valid_q <= 1'b0;
      b_rdy_q   <= 1'b0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      a_idx_q   <= a_idx_d;
      raw_q     <= raw_d;
      a_valid_q <= a_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_valid_q <= y_valid_d;
      b_rdy_q   <= b_rdy_d;
      status_q  <= status_d;
    end
  end

  assign a_tdata  = a_idx_q;
  assign raw      = raw_q;
  assign a_tvalid = a_valid_q;
  assign y_tdata  = y_data_q;
  assign y_tlast  = y_last_q;
  assign y_tvalid = y_valid_q;
  assign status   = status_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_dense_stream_layer.sv
// Bench for dense_stream_layer: default instance plus a 12-bit-accumulator
// instance, table-driven scenarios, random frames against an integer model.
module tb_dense_stream_layer;

  localparam int NO = 10;
  localparam int NI = 160;
  localparam int XB = 4;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NO*WB-1:0] b_tdata, w_tdata;
  logic [XB-1:0]    x_tdata;
  logic b_tvalid1, b_tvalid2, x_tvalid, w_tvalid, mode, a_tready, y_tready;

  logic        b_tready1, x_tready1, w_tready1, a_tvalid1, y_tlast1, y_tvalid1, sat1;
  logic [3:0]  a_tdata1;
  logic [15:0] raw1;
  logic [XB-1:0] y_tdata1;
  logic [1:0]  status1;

  logic        b_tready2, x_tready2, w_tready2, a_tvalid2, y_tlast2, y_tvalid2, sat2;
  logic [3:0]  a_tdata2;
  logic [11:0] raw2;
  logic [XB-1:0] y_tdata2;
  logic [1:0]  status2;

  dense_stream_layer u_dut (
    .clk(clk), .rst_n(rst_n),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid1), .b_tready(b_tready1),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready1),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready1),
    .mode(mode),
    .a_tdata(a_tdata1), .raw(raw1), .a_tvalid(a_tvalid1), .a_tready(a_tready),
    .y_tdata(y_tdata1), .y_tlast(y_tlast1), .y_tvalid(y_tvalid1), .y_tready(y_tready),
    .status(status1), .sat(sat1)
  );

  dense_stream_layer #(.ACC_BITS(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid2), .b_tready(b_tready2),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready2),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready2),
    .mode(mode),
    .a_tdata(a_tdata2), .raw(raw2), .a_tvalid(a_tvalid2), .a_tready(a_tready),
    .y_tdata(y_tdata2), .y_tlast(y_tlast2), .y_tvalid(y_tvalid2), .y_tready(y_tready),
    .status(status2), .sat(sat2)
  );

  // View of whichever instance the current frame targets.
  int cur_sel = 0;
  logic m_brdy, m_xrdy, m_wrdy, m_av, m_yv, m_yl, m_sat;
  int   m_idx, m_raw, m_y, m_st;
  always_comb begin
    m_brdy = cur_sel != 0 ? b_tready2 : b_tready1;
    m_xrdy = cur_sel != 0 ? x_tready2 : x_tready1;
    m_wrdy = cur_sel != 0 ? w_tready2 : w_tready1;
    m_av   = cur_sel != 0 ? a_tvalid2 : a_tvalid1;
    m_yv   = cur_sel != 0 ? y_tvalid2 : y_tvalid1;
    m_yl   = cur_sel != 0 ? y_tlast2  : y_tlast1;
    m_sat  = cur_sel != 0 ? sat2      : sat1;
    m_idx  = cur_sel != 0 ? int'(a_tdata2) : int'(a_tdata1);
    m_raw  = cur_sel != 0 ? int'($signed(raw2)) : int'($signed(raw1));
    m_y    = cur_sel != 0 ? int'(y_tdata2) : int'(y_tdata1);
    m_st   = cur_sel != 0 ? int'(status2) : int'(status1);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int bias[NO];
  int wt[NI][NO];
  int xs[NI];
  int e_raw, e_idx, e_sat;
  int e_y[NO];

  int g_idx, g_raw, g_sat, g_rise, g_done;
  int g_y[$];
  int g_last[$];

  task automatic fill(input int kind);
    for (int j = 0; j < NI; j++) begin
      case (kind)
        0: xs[j] = 15;
        2: xs[j] = 15;
        3: xs[j] = 1;
        5: xs[j] = int'($urandom_range(3));
        default: xs[j] = int'($urandom_range(15));
      endcase
      for (int o = 0; o < NO; o++) begin
        case (kind)
          0: wt[j][o] = (o == 3) ? 1 : 0;
          1: wt[j][o] = 0;
          2: wt[j][o] = (o == 0) ? 7 : 0;
          3: wt[j][o] = (o % 2 == 1) ? 1 : -1;
          5: wt[j][o] = int'($urandom_range(2)) - 1;
          default: wt[j][o] = int'($urandom_range(15)) - 8;
        endcase
      end
    end
    for (int o = 0; o < NO; o++) begin
      case (kind)
        0, 2, 3: bias[o] = 0;
        1: bias[o] = (o == 2 || o == 7) ? 3 : -1;
        default: bias[o] = int'($urandom_range(15)) - 8;
      endcase
    end
  endtask

  // Reference: plain integer sums with clamping after every beat.
  task automatic model(input int ab);
    int lo, hi;
    int acc[NO];
    lo = -(1 << (ab - 1));
    hi = (1 << (ab - 1)) - 1;
    e_sat = 0;
    for (int o = 0; o < NO; o++) begin
      acc[o] = bias[o] * 16;
      for (int j = 0; j < NI; j++) begin
        acc[o] = acc[o] + wt[j][o] * xs[j];
        if (acc[o] > hi) begin acc[o] = hi; e_sat = 1; end
        else if (acc[o] < lo) begin acc[o] = lo; e_sat = 1; end
      end
    end
    e_idx = 0;
    for (int o = 1; o < NO; o++) if (acc[o] > acc[e_idx]) e_idx = o;
    e_raw = acc[e_idx];
    for (int o = 0; o < NO; o++)
      e_y[o] = (acc[o] < 0) ? 0 : ((acc[o] / 16 > 15) ? 15 : acc[o] / 16);
  endtask

  // Drive one frame; called and returns #1 after a rising edge.
  task automatic run_frame(input int sel, input bit m, input int gap, input int a_stall,
                           input int y_gap, input int abort_at);
    int bi, t, c0, stall, held_idx, held_raw, prev_y;
    bit bias_done, seen, prev_yhold, bf, xf, af, yf;
    bi = 0; t = 0; c0 = 0; stall = 0; held_idx = 0; held_raw = 0; prev_y = 0;
    bias_done = 0; seen = 0; prev_yhold = 0;
    cur_sel = sel;
    g_y.delete(); g_last.delete();
    g_done = 0; g_rise = -1;
    #0;
    while (g_done == 0 && t < 4000) begin
      for (int o = 0; o < NO; o++) b_tdata[o*WB +: WB] = WB'(bias[o]);
      if (!bias_done) begin
        mode = m;
        b_tvalid1 = (sel == 0);
        b_tvalid2 = (sel != 0);
      end else begin
        mode = ~m;
        b_tvalid1 = 1'b0;
        b_tvalid2 = 1'b0;
      end
      if (bias_done && bi < NI) begin
        x_tvalid = int'($urandom_range(99)) >= gap;
        w_tvalid = int'($urandom_range(99)) >= gap;
        x_tdata = XB'(xs[bi]);
        for (int o = 0; o < NO; o++) w_tdata[o*WB +: WB] = WB'(wt[bi][o]);
      end else begin
        x_tvalid = 1'b0;
        w_tvalid = 1'b0;
        x_tdata = XB'($urandom);
        w_tdata = {$urandom, $urandom};
      end
      a_tready = m_av && (stall >= a_stall);
      if (m_av) stall++;
      y_tready = int'($urandom_range(99)) >= y_gap;
      @(negedge clk);
      bf = (sel != 0 ? b_tvalid2 : b_tvalid1) && m_brdy;
      xf = x_tvalid && w_tvalid && m_xrdy && m_wrdy;
      if (m_av) begin
        chk("a_hold_idx", m_idx, held_idx);
        chk("a_hold_raw", m_raw, held_raw);
      end
      if (m_yv && prev_yhold) chk("y_hold", m_y, prev_y);
      prev_yhold = m_yv && !y_tready;
      prev_y = m_y;
      af = m_av && a_tready;
      yf = m_yv && y_tready;
      @(posedge clk);
      t++;
      if (bf) begin bias_done = 1; c0 = t; end
      if (xf) bi++;
      if (af) begin g_idx = m_idx; g_raw = m_raw; g_done = 1; end
      if (yf) begin
        g_y.push_back(m_y);
        g_last.push_back(int'(m_yl));
        if (m_yl || g_y.size() >= NO) g_done = 1;
      end
      #1;
      if (bf) begin
        chk("status_busy", m_st, 1);
        chk("sat_clr_on_bias", int'(m_sat), 0);
      end
      if (abort_at >= 0 && bi >= abort_at) return;
      if (!seen && (m_av || m_yv)) begin
        seen = 1;
        g_rise = t - c0 + 1;
        held_idx = m_idx;
        held_raw = m_raw;
        chk("status_out", m_st, 2);
      end
    end
    b_tvalid1 = 1'b0; b_tvalid2 = 1'b0; x_tvalid = 1'b0; w_tvalid = 1'b0;
    if (g_done == 0) begin
      chk("frame_timeout", 0, 1);
    end else begin
      chk("status_idle", m_st, 0);
      chk("valid_drop", int'(m_av) + int'(m_yv), 0);
      g_sat = int'(m_sat);
    end
  endtask

  typedef struct {
    string name;
    int kind;
    bit mode;
    int sel;
    int gap;
    int a_stall;
    int exp_idx;   // -1: take from model
    int exp_raw;
    int exp_sat;   // -1: take from model
    int exp_rise;  // -1: not checked
  } vec_t;

  vec_t tbl[6];

  initial begin
    b_tdata = '0; w_tdata = '0; x_tdata = '0;
    b_tvalid1 = 0; b_tvalid2 = 0; x_tvalid = 0; w_tvalid = 0;
    mode = 0; a_tready = 0; y_tready = 0;

    tbl[0] = '{"argmax",       0, 1'b0, 0,  0, 0,  3, 2400,  0, 171};
    tbl[1] = '{"tie_bias",     1, 1'b0, 0,  0, 0,  2,   48,  0, 171};
    tbl[2] = '{"sat12",        2, 1'b0, 1,  0, 0,  0, 2047,  1, 171};
    tbl[3] = '{"sat_cleared",  5, 1'b0, 1,  0, 0, -1,   -1,  0, 171};
    tbl[4] = '{"relu",         3, 1'b1, 0,  0, 0, -1,   -1, -1, 161};
    tbl[5] = '{"backpressure", 0, 1'b0, 0, 50, 5,  3, 2400,  0,  -1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_tready", int'(b_tready1), 0);
    chk("rst_a_tvalid", int'(a_tvalid1), 0);
    chk("rst_y_tvalid", int'(y_tvalid1), 0);
    chk("rst_status", int'(status1), 0);
    chk("rst_raw", int'(raw1), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_b_tready", int'(b_tready1), 1);

    foreach (tbl[i]) begin
      fill(tbl[i].kind);
      model(tbl[i].sel != 0 ? 12 : 16);
      run_frame(tbl[i].sel, tbl[i].mode, tbl[i].gap, tbl[i].a_stall, 0, -1);
      if (tbl[i].exp_rise >= 0) chk({tbl[i].name, "_rise"}, g_rise, tbl[i].exp_rise);
      chk({tbl[i].name, "_sat"}, g_sat, tbl[i].exp_sat >= 0 ? tbl[i].exp_sat : e_sat);
      if (tbl[i].mode == 1'b0) begin
        chk({tbl[i].name, "_idx"}, g_idx, tbl[i].exp_idx >= 0 ? tbl[i].exp_idx : e_idx);
        chk({tbl[i].name, "_raw"}, g_raw, tbl[i].exp_idx >= 0 ? tbl[i].exp_raw : e_raw);
      end else begin
        chk({tbl[i].name, "_ylen"}, g_y.size(), NO);
        for (int k = 0; k < NO && k < g_y.size(); k++) begin
          chk({tbl[i].name, "_y"}, g_y[k], (tbl[i].kind == 3) ? ((k % 2 == 1) ? 10 : 0) : e_y[k]);
          chk({tbl[i].name, "_ylast"}, g_last[k], (k == NO - 1) ? 1 : 0);
        end
      end
    end

    for (int r = 0; r < 8; r++) begin
      bit m;
      int sel;
      sel = r % 2;
      m = ((r / 2) % 2) == 1;
      fill(4);
      model(sel != 0 ? 12 : 16);
      run_frame(sel, m, 30, int'($urandom_range(3)), m ? 40 : 0, -1);
      chk("rand_sat", g_sat, e_sat);
      if (!m) begin
        chk("rand_idx", g_idx, e_idx);
        chk("rand_raw", g_raw, e_raw);
      end else begin
        chk("rand_ylen", g_y.size(), NO);
        for (int k = 0; k < NO && k < g_y.size(); k++) begin
          chk("rand_y", g_y[k], e_y[k]);
          chk("rand_ylast", g_last[k], (k == NO - 1) ? 1 : 0);
        end
      end
    end

    // Mid-frame reset after 50 beats, then a clean frame.
    fill(0);
    model(16);
    run_frame(0, 1'b0, 0, 0, 0, -1);
    run_frame(0, 1'b0, 0, 0, 0, 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b_tready", int'(b_tready1), 0);
    chk("mid_rst_x_tready", int'(x_tready1), 0);
    chk("mid_rst_a_tvalid", int'(a_tvalid1), 0);
    chk("mid_rst_raw", int'(raw1), 0);
    chk("mid_rst_a_tdata", int'(a_tdata1), 0);
    chk("mid_rst_status", int'(status1), 0);
    chk("mid_rst_y", int'(y_tvalid1) + int'(y_tlast1) + int'(y_tdata1) + int'(sat1), 0);
    x_tvalid = 1'b0;
    w_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_b_tready", int'(b_tready1), 1);
    run_frame(0, 1'b0, 0, 0, 0, -1);
    chk("post_rst_idx", g_idx, 3);
    chk("post_rst_raw", g_raw, 2400);
    chk("post_rst_rise", g_rise, 171);
    chk("post_rst_sat", g_sat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
